// File: rtl/operand_b_stage.sv
// operand_b_stage: registered ALU operand-B select with forwarding, stall refresh and flush
module operand_b_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [15:0]              id_instr,
  input  logic [REG_AW-1:0]        id_ry_addr,
  input  logic [DATA_W-1:0]        id_ry_data,
  input  logic [DATA_W-1:0]        id_imm,
  input  logic [FWD_N-1:0]         fwd_valid,
  input  logic [FWD_N*REG_AW-1:0]  fwd_addr,
  input  logic [FWD_N*DATA_W-1:0]  fwd_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic [1:0]               ex_selb,
  output logic [DATA_W-1:0]        ex_opb,
  output logic                     ex_fwd_hit,
  output logic [CNT_W-1:0]         fwd_hit_cnt
);
  logic [4:0]        op;
  logic              is_ry, is_imm, id_hit, hold_hit, res_hit;
  logic [1:0]        res_sel;
  logic [DATA_W-1:0] id_fdata, hold_fdata, res_opb;
  logic [REG_AW-1:0] ex_ry_addr;
  logic              unused_bits;
  assign op = id_instr[15:11];
  assign unused_bits = ^id_instr[7:5];
  assign is_ry = (op == 5'b11100 && id_instr[1:0] inside {2'b01, 2'b11}) ||
                 (op == 5'b11101 && id_instr[4:0] inside {5'b01100, 5'b01010, 5'b01011, 5'b01101, 5'b00010}) ||
                 (op == 5'b01111 && id_instr[4:0] == 5'b00000);
  assign is_imm = (op == 5'b00110 && id_instr[1:0] inside {2'b00, 2'b11}) ||
                  (op inside {5'b01000, 5'b01001, 5'b01011, 5'b01101, 5'b10010, 5'b10011, 5'b11010, 5'b11011}) ||
                  (id_instr[15:8] == 8'b01100011);
  // Forward lookup for the ID ry and the held EX ry; scanning downward lets index 0 win
  always_comb begin
    id_hit = 1'b0;
    id_fdata = '0;
    hold_hit = 1'b0;
    hold_fdata = '0;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == id_ry_addr) begin
        id_hit = 1'b1;
        id_fdata = fwd_data[i*DATA_W +: DATA_W];
      end
      if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == ex_ry_addr) begin
        hold_hit = 1'b1;
        hold_fdata = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end
  // Resolve class and operand for the instruction in ID
  always_comb begin
    res_sel = is_ry ? 2'b00 : is_imm ? 2'b01 : 2'b10;
    res_hit = is_ry && id_hit;
    res_opb = is_ry ? (id_hit ? id_fdata : id_ry_data) : is_imm ? id_imm : '0;
  end
  // EX register: rst > flush > stall (with ry refresh) > load; bubbles on invalid ID
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_selb <= 2'b10;
      ex_opb <= '0;
      ex_fwd_hit <= 1'b0;
      ex_ry_addr <= '0;
      fwd_hit_cnt <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid <= 1'b0;
      ex_selb <= 2'b10;
      ex_opb <= '0;
      ex_fwd_hit <= 1'b0;
    end else if (stall) begin
      if (ex_valid && ex_selb == 2'b00 && hold_hit) begin
        ex_opb <= hold_fdata;
        ex_fwd_hit <= 1'b1;
      end
    end else begin
      ex_valid <= 1'b1;
      ex_selb <= res_sel;
      ex_opb <= res_opb;
      ex_fwd_hit <= res_hit;
      ex_ry_addr <= id_ry_addr;
      if (res_hit && fwd_hit_cnt != '1) fwd_hit_cnt <= fwd_hit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_operand_b_stage.sv
// tb_operand_b_stage: scoreboard bench for operand_b_stage
module tb_operand_b_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, stall, flush;
  logic [15:0] id_instr, id_ry_data, id_imm;
  logic [3:0]  id_ry_addr;
  logic [1:0]  fwd_valid;
  logic [7:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        ex_valid, ex_fwd_hit;
  logic [1:0]  ex_selb;
  logic [15:0] ex_opb;
  logic [7:0]  fwd_hit_cnt;
  logic        unused_v2, unused_h2;
  logic [1:0]  unused_s2, cnt2;
  logic [15:0] unused_o2;
  logic [27:0] q[$];
  logic [27:0] obs, exp_v;
  logic [7:0]  exp_cnt;
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;
  assign obs = {ex_valid, ex_selb, ex_opb, ex_fwd_hit, fwd_hit_cnt};

  operand_b_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_ry_addr(id_ry_addr),
    .id_ry_data(id_ry_data), .id_imm(id_imm), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_selb(ex_selb),
    .ex_opb(ex_opb), .ex_fwd_hit(ex_fwd_hit), .fwd_hit_cnt(fwd_hit_cnt)
  );

  operand_b_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_ry_addr(id_ry_addr),
    .id_ry_data(id_ry_data), .id_imm(id_imm), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .stall(stall), .flush(flush), .ex_valid(unused_v2), .ex_selb(unused_s2),
    .ex_opb(unused_o2), .ex_fwd_hit(unused_h2), .fwd_hit_cnt(cnt2)
  );

  task automatic set_in(input logic v, input logic [15:0] ins, input logic [3:0] ra,
                        input logic [15:0] rd, input logic [15:0] im, input logic [1:0] fv,
                        input logic [7:0] fa, input logic [31:0] fd, input logic st, input logic fl);
    id_valid = v; id_instr = ins; id_ry_addr = ra; id_ry_data = rd; id_imm = im;
    fwd_valid = fv; fwd_addr = fa; fwd_data = fd; stall = st; flush = fl;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_in(1'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
             2'($urandom), 8'($urandom), $urandom, 1'($urandom), 1'($urandom));
      exp_cnt = 8'd0;
      q.push_back({1'b0, 2'b10, 16'h0000, 1'b0, 8'd0});
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL reset[%0d]: got %h expected %h", k, obs, exp_v); end
      vectors++;
      if (cnt2 !== 2'd0) begin miscompares++; $display("FAIL reset_cnt2[%0d]: got %0d expected 0", k, cnt2); end
    end
    rst = 1'b0;
  endtask

  task automatic test_ry_forward;
    logic [1:0]  fvs[5]  = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
    logic [7:0]  fas[5]  = '{8'h33, 8'h33, 8'h33, 8'h56, 8'h53};
    logic [15:0] opbs[5] = '{16'h1234, 16'hAAAA, 16'hBBBB, 16'h1234, 16'hAAAA};
    logic        hits[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 16'hE001, 4'd3, 16'h1234, 16'h0000, fvs[k], fas[k], 32'hBBBBAAAA, 1'b0, 1'b0);
      if (hits[k]) exp_cnt++;
      q.push_back({1'b1, 2'b00, opbs[k], hits[k], exp_cnt});
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL ry_forward[%0d]: got %h expected %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_classify;
    logic [15:0] ins[20] = '{16'hE001, 16'hE003, 16'hE000, 16'hE80C, 16'hE80A, 16'hE80B, 16'hE80D,
                             16'hE802, 16'hE80E, 16'h7800, 16'h7801, 16'h3000, 16'h3003, 16'h3001,
                             16'h4000, 16'h9800, 16'h6300, 16'h6400, 16'hD800, 16'h0800};
    logic [1:0]  sel[20] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10,
                             2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] eo;
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, ins[k], 4'd3, 16'h1234, 16'h0007, 2'b01, 8'h03, 32'hBBBBAAAA, 1'b0, 1'b0);
      eo = sel[k] == 2'b00 ? 16'hAAAA : sel[k] == 2'b01 ? 16'h0007 : 16'h0000;
      if (sel[k] == 2'b00) exp_cnt++;
      q.push_back({1'b1, sel[k], eo, sel[k] == 2'b00, exp_cnt});
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL classify[%04h]: got %h expected %h", ins[k], obs, exp_v); end
    end
  endtask

  task automatic test_bubble;
    set_in(1'b0, 16'hE001, 4'd3, 16'h1234, 16'h0007, 2'b01, 8'h03, 32'hBBBBAAAA, 1'b0, 1'b0);
    q.push_back({1'b0, 2'b10, 16'h0000, 1'b0, exp_cnt});
    @(posedge clk); #1;
    exp_v = q.pop_front();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL bubble: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_stall_refresh;
    logic [15:0] ins[5] = '{16'hE001, 16'h9800, 16'h9800, 16'h9800, 16'h9800};
    logic [1:0]  fvs[5] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b11};
    logic        sts[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [27:0] ex[5];
    ex[0] = {1'b1, 2'b00, 16'h1111, 1'b0, exp_cnt};
    ex[1] = {1'b1, 2'b00, 16'h5555, 1'b1, exp_cnt};
    ex[2] = {1'b1, 2'b00, 16'h5555, 1'b1, exp_cnt};
    ex[3] = {1'b1, 2'b01, 16'h0009, 1'b0, exp_cnt};
    ex[4] = {1'b1, 2'b01, 16'h0009, 1'b0, exp_cnt};
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, ins[k], 4'd5, 16'h1111, 16'h0009, fvs[k], 8'h55, 32'h5555EEEE, sts[k], 1'b0);
      q.push_back(ex[k]);
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL stall_refresh[%0d]: got %h expected %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_flush;
    logic        sts[3] = '{1'b0, 1'b1, 1'b0};
    logic        fls[3] = '{1'b0, 1'b1, 1'b1};
    logic [27:0] ex[3];
    ex[0] = {1'b1, 2'b01, 16'h0042, 1'b0, exp_cnt};
    ex[1] = {1'b0, 2'b10, 16'h0000, 1'b0, exp_cnt};
    ex[2] = {1'b0, 2'b10, 16'h0000, 1'b0, exp_cnt};
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 16'h4000, 4'd2, 16'h7777, 16'h0042, 2'b00, 8'h00, 32'h0, sts[k], fls[k]);
      q.push_back(ex[k]);
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL flush[%0d]: got %h expected %h", k, obs, exp_v); end
    end
  endtask

  task automatic test_saturation;
    logic [1:0] e2;
    rst = 1'b1;
    exp_cnt = 8'd0;
    q.push_back({1'b0, 2'b10, 16'h0000, 1'b0, 8'd0});
    @(posedge clk); #1;
    exp_v = q.pop_front();
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL sat_reset: got %h expected %h", obs, exp_v); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 16'hE001, 4'd3, 16'h1234, 16'h0000, 2'b01, 8'h03, 32'hBBBBAAAA, 1'b0, 1'b0);
      exp_cnt++;
      q.push_back({1'b1, 2'b00, 16'hAAAA, 1'b1, exp_cnt});
      e2 = k > 3 ? 2'd3 : 2'(k);
      @(posedge clk); #1;
      exp_v = q.pop_front();
      vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL sat_main[%0d]: got %h expected %h", k, obs, exp_v); end
      vectors++;
      if (cnt2 !== e2) begin miscompares++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", k, cnt2, e2); end
    end
  endtask

  initial begin
    set_in(1'b0, 16'h0, 4'd0, 16'h0, 16'h0, 2'b00, 8'h00, 32'h0, 1'b0, 1'b0);
    test_reset;
    test_ry_forward;
    test_classify;
    test_bubble;
    test_stall_refresh;
    test_flush;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
